// File: rtl/vx_tcu_issue_sequencer.sv
// Batch issue sequencer for the TCU dispatch/commit protocol: tags and issues operands
// under an in-flight cap, checks in-order result tags and forwards result payloads.
module vx_tcu_issue_sequencer #(
    parameter int unsigned REQ_WIDTH   = 64,
    parameter int unsigned RSP_WIDTH   = 64,
    parameter int unsigned TAG_WIDTH   = 4,
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,

    input  logic                           start,
    input  logic [CNT_WIDTH-1:0]           batch_len,
    output logic                           busy,
    output logic                           done,
    output logic                           err,

    input  logic                           req_valid,
    input  logic [REQ_WIDTH-1:0]           req_data,
    output logic                           req_ready,

    output logic                           execute_valid,
    output logic [TAG_WIDTH+REQ_WIDTH-1:0] execute_data,
    input  logic                           execute_ready,

    input  logic                           result_valid,
    input  logic [TAG_WIDTH+RSP_WIDTH-1:0] result_data,
    output logic                           result_ready,

    output logic                           rsp_valid,
    output logic [RSP_WIDTH-1:0]           rsp_data,
    input  logic                           rsp_ready
);

    localparam int unsigned PEND_WIDTH = $clog2(MAX_PENDING + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] tag;
        logic [RSP_WIDTH-1:0] payload;
    } result_t;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   issue_left_q, issue_left_d;
    logic [CNT_WIDTH-1:0]   retire_left_q, retire_left_d;
    logic [TAG_WIDTH-1:0]   issue_tag_q, issue_tag_d;
    logic [TAG_WIDTH-1:0]   exp_tag_q, exp_tag_d;
    logic [PEND_WIDTH-1:0]  pending_q, pending_d;
    logic                   err_q, err_d;

    logic    can_issue;
    logic    can_retire;
    logic    issue_fire;
    logic    retire_fire;
    result_t result;

    assign result = result_data;

    // Handshake gating: both paths are zero-latency pass-throughs qualified by state.
    always_comb begin
        can_issue  = (state_q == S_ISSUE)
                     && (pending_q < PEND_WIDTH'(MAX_PENDING))
                     && (issue_left_q != '0);
        can_retire = ((state_q == S_ISSUE) || (state_q == S_DRAIN))
                     && (pending_q != '0);
    end

    assign execute_valid = req_valid && can_issue;
    assign req_ready     = execute_ready && can_issue;
    assign execute_data  = {issue_tag_q, req_data};
    assign issue_fire    = execute_valid && execute_ready;

    assign rsp_valid     = result_valid && can_retire;
    assign result_ready  = rsp_ready && can_retire;
    assign rsp_data      = result.payload;
    assign retire_fire   = result_valid && result_ready;

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign err  = err_q;

    // Next-state and counter update.
    always_comb begin
        state_d       = state_q;
        issue_left_d  = issue_left_q;
        retire_left_d = retire_left_q;
        issue_tag_d   = issue_tag_q;
        exp_tag_d     = exp_tag_q;
        pending_d     = pending_q;
        err_d         = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (batch_len != '0) begin
                        issue_left_d  = batch_len;
                        retire_left_d = batch_len;
                        issue_tag_d   = '0;
                        exp_tag_d     = '0;
                        pending_d     = '0;
                        state_d       = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_ISSUE, S_DRAIN: begin
                if (issue_fire) begin
                    issue_left_d = issue_left_q - CNT_WIDTH'(1);
                    issue_tag_d  = issue_tag_q + TAG_WIDTH'(1);
                end
                if (retire_fire) begin
                    retire_left_d = retire_left_q - CNT_WIDTH'(1);
                    exp_tag_d     = exp_tag_q + TAG_WIDTH'(1);
                    if (result.tag != exp_tag_q) begin
                        err_d = 1'b1;
                    end
                end
                // Simultaneous issue and retire leave the in-flight count unchanged.
                unique case ({issue_fire, retire_fire})
                    2'b10:   pending_d = pending_q + PEND_WIDTH'(1);
                    2'b01:   pending_d = pending_q - PEND_WIDTH'(1);
                    default: pending_d = pending_q;
                endcase
                if ((state_q == S_ISSUE) && issue_fire
                    && (issue_left_q == CNT_WIDTH'(1))) begin
                    state_d = S_DRAIN;
                end
                if ((state_q == S_DRAIN) && retire_fire
                    && (retire_left_q == CNT_WIDTH'(1))) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            issue_left_q  <= '0;
            retire_left_q <= '0;
            issue_tag_q   <= '0;
            exp_tag_q     <= '0;
            pending_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_left_q  <= issue_left_d;
            retire_left_q <= retire_left_d;
            issue_tag_q   <= issue_tag_d;
            exp_tag_q     <= exp_tag_d;
            pending_q     <= pending_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_vx_tcu_issue_sequencer.sv
// Bench for vx_tcu_issue_sequencer: a table of batches run with random handshakes against
// a count-based model, plus hand sequences for reset, the credit cap and mid-batch reset.
module tb_vx_tcu_issue_sequencer;

    localparam int unsigned RW   = 16;
    localparam int unsigned SW   = 16;
    localparam int unsigned TW   = 2;
    localparam int unsigned MP   = 4;
    localparam int unsigned CW   = 8;
    localparam int          TMOD = 1 << TW;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [CW-1:0]     batch_len;
    logic              busy, done, err;
    logic              req_valid, req_ready;
    logic [RW-1:0]     req_data;
    logic              execute_valid, execute_ready;
    logic [TW+RW-1:0]  execute_data;
    logic              result_valid, result_ready;
    logic [TW+SW-1:0]  result_data;
    logic              rsp_valid, rsp_ready;
    logic [SW-1:0]     rsp_data;

    vx_tcu_issue_sequencer #(
        .REQ_WIDTH(RW), .RSP_WIDTH(SW), .TAG_WIDTH(TW), .MAX_PENDING(MP), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .start(start), .batch_len(batch_len),
        .busy(busy), .done(done), .err(err),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .execute_valid(execute_valid), .execute_data(execute_data), .execute_ready(execute_ready),
        .result_valid(result_valid), .result_data(result_data), .result_ready(result_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tag;
        logic [RW-1:0] data;
    } tcu_ent_t;

    typedef struct {
        int len;
        int bad;
        bit exp_err;
        int p_req;
        int p_xr;
        int p_rr;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Model: a batch is a count of issues and retires; the TCU is a FIFO of tagged operands.
    int       m_len, m_issued, m_retired;
    bit       m_active, m_done, m_err;
    tcu_ent_t tq[$];
    bit       req_hold, res_hold;
    int       bad_idx;
    int       act_issued;
    int       p_req, p_xr, p_rr, p_res;
    bit       res_en;

    function automatic logic [SW-1:0] xform(input logic [RW-1:0] d);
        return {d[7:0], d[15:8]} ^ 16'h5a5a;
    endfunction

    function automatic logic [6:0] outs();
        return {execute_valid, req_ready, rsp_valid, result_ready, busy, done, err};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, want);
    endtask

    task automatic model_clear();
        m_len = 0; m_issued = 0; m_retired = 0;
        m_active = 1'b0; m_done = 1'b0; m_err = 1'b0;
        tq.delete();
        req_hold = 1'b0; res_hold = 1'b0;
    endtask

    task automatic step(input bit do_start, input int len);
        int        pend;
        bit        ci, cr, fi, fr, from_tq;
        logic [6:0] e_ctl;
        @(posedge clk); #1;
        start     = do_start;
        batch_len = CW'(len);
        if (!req_hold) begin
            req_valid = ($urandom_range(0, 99) < p_req);
            req_data  = RW'($urandom);
        end
        execute_ready = ($urandom_range(0, 99) < p_xr);
        rsp_ready     = ($urandom_range(0, 99) < p_rr);
        from_tq = res_hold;
        if (!res_hold) begin
            if (res_en && tq.size() > 0 && $urandom_range(0, 99) < p_res) begin
                result_valid = 1'b1;
                result_data  = {tq[0].tag, xform(tq[0].data)};
                from_tq      = 1'b1;
            end else if (!m_active && tq.size() == 0) begin
                result_valid = $urandom_range(0, 1) == 1;
                result_data  = (TW+SW)'($urandom);
            end else begin
                result_valid = 1'b0;
            end
        end
        #2;
        pend  = m_issued - m_retired;
        ci    = m_active && pend < MP && m_issued < m_len;
        cr    = m_active && pend != 0;
        e_ctl = {req_valid && ci, execute_ready && ci, result_valid && cr, rsp_ready && cr,
                 m_active || m_done, m_done, m_err};
        chk("ctl", outs(), e_ctl);
        if (e_ctl[6]) chk("exec_data", execute_data, {TW'(m_issued % TMOD), req_data});
        if (e_ctl[4] && tq.size() > 0) chk("rsp_data", rsp_data, xform(tq[0].data));
        if (execute_valid && execute_ready) act_issued++;
        fi = e_ctl[6] && execute_ready;
        fr = e_ctl[4] && rsp_ready;
        if (m_done) begin
            m_done = 1'b0;
        end else if (!m_active) begin
            if (do_start) begin
                m_len = len; m_issued = 0; m_retired = 0; m_err = 1'b0;
                if (len == 0) m_done = 1'b1;
                else m_active = 1'b1;
            end
        end else begin
            if (fi) begin
                tcu_ent_t ent;
                ent.tag  = TW'(m_issued % TMOD);
                if (m_issued == bad_idx) ent.tag = ent.tag ^ TW'(3);
                ent.data = req_data;
                tq.push_back(ent);
                m_issued++;
            end
            if (fr) begin
                if (tq[0].tag != TW'(m_retired % TMOD)) m_err = 1'b1;
                void'(tq.pop_front());
                m_retired++;
                if (m_retired == m_len) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end
        req_hold = req_valid && !fi;
        res_hold = result_valid && from_tq && !fr;
    endtask

    // Runs until the model returns to idle, pulsing ignored starts along the way.
    task automatic finish_batch(input int maxcyc);
        int cyc = 0;
        while ((m_active || m_done) && cyc < maxcyc) begin
            step($urandom_range(0, 7) == 0, int'($urandom_range(0, 255)));
            cyc++;
        end
        chk("batch_end", {m_active, m_done}, 0);
    endtask

    task automatic run_batch(input int len, input int bad, input bit exp_err);
        act_issued = 0;
        bad_idx    = bad;
        step(1'b1, len);
        finish_batch(2000);
        chk("issued", act_issued, len);
        chk("err_final", err, exp_err);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{3,  -1, 1'b0, 100, 100, 100};
        vecs[1] = '{3,   1, 1'b1, 100, 100, 100};
        vecs[2] = '{6,  -1, 1'b0, 100, 100, 100};
        vecs[3] = '{0,  -1, 1'b0, 100, 100, 100};
        vecs[4] = '{1,  -1, 1'b0,  50,  50,  50};
        vecs[5] = '{20, -1, 1'b0,  60,  70,  50};
        vecs[6] = '{17,  5, 1'b1,  50,  50,  50};
        vecs[7] = '{40, -1, 1'b0,  90,  30,  90};
        vecs[8] = '{12, 11, 1'b1,  80,  80,  80};

        reset_n = 1'b0; start = 1'b0; batch_len = '0;
        req_valid = 1'b0; req_data = '0; execute_ready = 1'b0;
        result_valid = 1'b0; result_data = '0; rsp_ready = 1'b0;
        model_clear();
        p_res = 70; res_en = 1'b1; bad_idx = -1; act_issued = 0;

        #2;
        chk("rst_ctl", outs(), 0);
        req_valid = 1'b1; execute_ready = 1'b1; result_valid = 1'b1; rsp_ready = 1'b1;
        start = 1'b1; batch_len = CW'(3);
        @(posedge clk); #1;
        chk("rst_ctl_driven", outs(), 0);
        start = 1'b0; req_valid = 1'b0; result_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            p_req = vecs[i].p_req; p_xr = vecs[i].p_xr; p_rr = vecs[i].p_rr;
            run_batch(vecs[i].len, vecs[i].bad, vecs[i].exp_err);
        end

        // Credit cap: no results returned, so issue stalls at MAX_PENDING.
        p_req = 100; p_xr = 100; p_rr = 100; p_res = 100; res_en = 1'b0;
        bad_idx = -1; act_issued = 0;
        step(1'b1, 6);
        for (int i = 0; i < 8; i++) step(1'b0, 0);
        chk("cap_issued", act_issued, 4);
        chk("cap_req_ready", req_ready, 0);
        res_en = 1'b1;
        step(1'b0, 0);
        chk("cap_hold", act_issued, 4);
        step(1'b0, 0);
        chk("cap_5th", act_issued, 5);
        finish_batch(200);
        chk("cap_total", act_issued, 6);

        // Asynchronous reset after two of five issues.
        res_en = 1'b0; act_issued = 0;
        step(1'b1, 5);
        for (int i = 0; i < 20 && act_issued < 2; i++) step(1'b0, 0);
        chk("mid_issued", act_issued, 2);
        @(posedge clk); #1;
        req_valid = 1'b1; execute_ready = 1'b1; result_valid = 1'b1; rsp_ready = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ctl", outs(), 0);
        model_clear();
        result_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        res_en = 1'b1; p_res = 70;
        run_batch(5, -1, 1'b0);

        // Random batches.
        for (int k = 0; k < 6; k++) begin
            int len = int'($urandom_range(1, 30));
            int bad = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1;
            p_req = int'($urandom_range(30, 100));
            p_xr  = int'($urandom_range(30, 100));
            p_rr  = int'($urandom_range(30, 100));
            run_batch(len, bad, bad >= 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
